axi_rd_arbiter: RTL

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arb_pkg.sv | 21 ++
 rtl/axi_rd_arbiter_if.sv | 52 +++++
 rtl/rr_arbiter.sv | 63 ++++++
 rtl/axi_rd_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/axi_rd_arb_pkg.sv
// Shared types and helpers for the AXI read-channel arbiter (axi_rd_arbiter).
package axi_rd_arb_pkg;

  typedef enum logic [0:0] {
    AR_IDLE  = 1'b0,
    AR_ISSUE = 1'b1
  } ar_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // ARSIZE encoding for a full-width beat: log2 of the bus width in bytes.
  function automatic logic [2:0] arsize_f(input int data_width);
    logic [2:0] size;
    size = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((8 << i) == data_width) size = 3'(i);
    end
    return size;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Bus bundle for axi_rd_arbiter: N requester AR/R channels plus one downstream AR/R channel.
interface axi_rd_arbiter_if #(
  parameter int N_MASTERS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  localparam int IW = $clog2(N_MASTERS);
  localparam int MW = ID_WIDTH + IW;

  logic [N_MASTERS-1:0]            s_arvalid;
  logic [N_MASTERS-1:0]            s_arready;
  logic [N_MASTERS*ADDR_WIDTH-1:0] s_araddr;
  logic [N_MASTERS*8-1:0]          s_arlen;
  logic [N_MASTERS*ID_WIDTH-1:0]   s_arid;
  logic [N_MASTERS-1:0]            s_rvalid;
  logic [N_MASTERS-1:0]            s_rready;
  logic [N_MASTERS-1:0]            s_rlast;
  logic [DATA_WIDTH-1:0]           s_rdata;
  logic [1:0]                      s_rresp;
  logic [ID_WIDTH-1:0]             s_rid;

  logic                  m_arvalid;
  logic                  m_arready;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [7:0]            m_arlen;
  logic [2:0]            m_arsize;
  logic [1:0]            m_arburst;
  logic [MW-1:0]         m_arid;
  logic                  m_rvalid;
  logic                  m_rready;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic [1:0]            m_rresp;
  logic [MW-1:0]         m_rid;
  logic                  m_rlast;

  // Arbiter side: accepts requester traffic and drives the shared downstream port.
  modport slave (
    input  s_arvalid, s_araddr, s_arlen, s_arid, s_rready,
           m_arready, m_rvalid, m_rdata, m_rresp, m_rid, m_rlast,
    output s_arready, s_rvalid, s_rlast, s_rdata, s_rresp, s_rid,
           m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_rready
  );

  // Environment side: requesters plus the downstream memory.
  modport master (
    output s_arvalid, s_araddr, s_arlen, s_arid, s_rready,
           m_arready, m_rvalid, m_rdata, m_rresp, m_rid, m_rlast,
    input  s_arready, s_rvalid, s_rlast, s_rdata, s_rresp, s_rid,
           m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_rready
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin request selector; with AXI_RD_ARB_PRIO_EN defined, request 0 always wins
// and the rest rotate among themselves.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);
  localparam logic [IW:0] N_L = (IW+1)'(N);

  logic [IW:0]   cand_s;
  logic [IW-1:0] rr_idx_s;
  logic          rr_valid_s;

  // Rotating search: first requester at or after ptr, wrapping modulo N.
  always_comb begin
    rr_idx_s   = '0;
    rr_valid_s = 1'b0;
    cand_s     = '0;
    for (int off = 0; off < N; off++) begin
      cand_s = {1'b0, ptr} + (IW+1)'(off);
      if (cand_s >= N_L) begin
        cand_s = cand_s - N_L;
      end else begin
        cand_s = cand_s;
      end
      if (!rr_valid_s && req[cand_s[IW-1:0]]) begin
        rr_valid_s = 1'b1;
        rr_idx_s   = cand_s[IW-1:0];
      end else begin
        rr_valid_s = rr_valid_s;
      end
    end
  end

  // Final pick and one-hot expansion.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
`ifdef AXI_RD_ARB_PRIO_EN
    if (req[0]) begin
      gnt_idx   = '0;
      gnt_valid = 1'b1;
    end else begin
      gnt_idx   = rr_idx_s;
      gnt_valid = rr_valid_s;
    end
`else
    gnt_idx   = rr_idx_s;
    gnt_valid = rr_valid_s;
`endif
    if (gnt_valid) begin
      gnt[gnt_idx] = 1'b1;
    end else begin
      gnt = '0;
    end
  end
endmodule

// File: rtl/axi_rd_arbiter.sv
// N-to-1 AXI read arbiter: AR arbitration with per-master outstanding limits, R routing by ID.
// Optional build macro AXI_RD_ARB_PRIO_EN gives master 0 strict priority.
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int N_MASTERS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_OUTST  = 4
) (
  input  logic             clk,
  input  logic             rstn,
  axi_rd_arbiter_if.slave  bus,
  output logic             rid_err
);
  localparam int IW = $clog2(N_MASTERS);
  localparam int MW = ID_WIDTH + IW;
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [IW:0]   N_L   = (IW+1)'(N_MASTERS);
  localparam logic [CW-1:0] MAX_L = CW'(MAX_OUTST);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_MASTERS - 1);

  ar_state_e             state_r, state_nxt_s;
  logic                  run_r;
  logic [IW-1:0]         rr_r, gnt_idx_s, rk_s;
  logic [N_MASTERS-1:0]  elig_s, gnt_s, rd_done_s, inc_s, dec_s;
  logic                  gnt_valid_s, grant_fire_s, rk_ok_s;
  logic [CW-1:0]         outst_r [N_MASTERS];
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [7:0]            len_r;
  logic [MW-1:0]         id_r;

  rr_arbiter #(.N(N_MASTERS)) u_sel (
    .req       (elig_s),
    .ptr       (rr_r),
    .gnt       (gnt_s),
    .gnt_idx   (gnt_idx_s),
    .gnt_valid (gnt_valid_s)
  );

  // Eligibility, grant qualification and outstanding-counter events.
  always_comb begin
    elig_s = '0;
    inc_s  = '0;
    dec_s  = '0;
    // run_r keeps the first cycle after reset grant-free.
    grant_fire_s = rstn && run_r && (state_r == AR_IDLE) && gnt_valid_s;
    for (int i = 0; i < N_MASTERS; i++) begin
      elig_s[i] = bus.s_arvalid[i] && (outst_r[i] < MAX_L);
      inc_s[i]  = grant_fire_s && gnt_s[i];
      dec_s[i]  = rd_done_s[i] && (outst_r[i] != '0);
    end
    if (grant_fire_s) begin
      bus.s_arready = gnt_s;
    end else begin
      bus.s_arready = '0;
    end
  end

  // AR FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= AR_IDLE;
      run_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      run_r   <= 1'b1;
    end
  end

  // AR FSM next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      AR_IDLE: begin
        if (grant_fire_s) state_nxt_s = AR_ISSUE;
        else              state_nxt_s = AR_IDLE;
      end
      AR_ISSUE: begin
        if (bus.m_arready) state_nxt_s = AR_IDLE;
        else               state_nxt_s = AR_ISSUE;
      end
      default: state_nxt_s = AR_IDLE;
    endcase
  end

  // Capture the winning request and advance the rotation pointer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_r <= '0;
      len_r  <= '0;
      id_r   <= '0;
      rr_r   <= '0;
    end else if (grant_fire_s) begin
      addr_r <= bus.s_araddr[gnt_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
      len_r  <= bus.s_arlen[gnt_idx_s*8 +: 8];
      id_r   <= {gnt_idx_s, bus.s_arid[gnt_idx_s*ID_WIDTH +: ID_WIDTH]};
      rr_r   <= (gnt_idx_s == LAST_IDX) ? '0 : gnt_idx_s + IW'(1);
    end else begin
      addr_r <= addr_r;
      len_r  <= len_r;
      id_r   <= id_r;
      rr_r   <= rr_r;
    end
  end

  // Outstanding-burst counters; a coincident grant and completion cancel out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_MASTERS; i++) begin
      if (!rstn)                      outst_r[i] <= '0;
      else if (inc_s[i] && !dec_s[i]) outst_r[i] <= outst_r[i] + CW'(1);
      else if (dec_s[i] && !inc_s[i]) outst_r[i] <= outst_r[i] - CW'(1);
      else                            outst_r[i] <= outst_r[i];
    end
  end

  // Sticky flag for R beats whose index names no requester.
  always_ff @(posedge clk) begin
    if (!rstn)                          rid_err <= 1'b0;
    else if (bus.m_rvalid && !rk_ok_s)  rid_err <= 1'b1;
    else                                rid_err <= rid_err;
  end

  // Zero-latency R routing; unroutable beats are accepted and dropped.
  always_comb begin
    rk_s          = bus.m_rid[MW-1:ID_WIDTH];
    rk_ok_s       = ({1'b0, rk_s} < N_L);
    bus.s_rvalid  = '0;
    bus.s_rlast   = '0;
    bus.m_rready  = 1'b1;
    rd_done_s     = '0;
    if (rk_ok_s) begin
      bus.s_rvalid[rk_s] = bus.m_rvalid;
      bus.s_rlast[rk_s]  = bus.m_rlast;
      bus.m_rready       = bus.s_rready[rk_s];
      rd_done_s[rk_s]    = bus.m_rvalid && bus.s_rready[rk_s] && bus.m_rlast;
    end else begin
      bus.m_rready = 1'b1;
    end
    bus.s_rdata = bus.m_rdata;
    bus.s_rresp = bus.m_rresp;
    bus.s_rid   = bus.m_rid[ID_WIDTH-1:0];
  end

  assign bus.m_arvalid = (state_r == AR_ISSUE);
  assign bus.m_araddr  = addr_r;
  assign bus.m_arlen   = len_r;
  assign bus.m_arid    = id_r;
  assign bus.m_arsize  = arsize_f(DATA_WIDTH);
  assign bus.m_arburst = AXI_BURST_INCR;
endmodule
